// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe board controller.
// Cell, winner and FSM state definitions.
package ttt_pkg;

  localparam logic [1:0] CELL_N = 2'b00;
  localparam logic [1:0] CELL_X = 2'b01;
  localparam logic [1:0] CELL_O = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b11;

  typedef enum logic [1:0] {
    PLAY,
    CHECK,
    OVER
  } state_t;

  function automatic logic [1:0] mark_of(input logic t);
    return t ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/board_cell.sv
// One board square: write-once 2-bit mark register.
// Cleared only by reset or the synchronous clr.
module board_cell
  import ttt_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  input  logic       clr,
  input  logic       we,
  input  logic       player,
  output logic [1:0] q
);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      q <= CELL_N;
    else if (clr)
      q <= CELL_N;
    else if (we && q == CELL_N)
      q <= mark_of(player);
  end

endmodule

// File: rtl/ttt_board.sv
// SIZE x SIZE tic-tac-toe controller: move handshake,
// turn alternation, win/draw detection and board lock.
module ttt_board
  import ttt_pkg::*;
#(
  parameter int SIZE         = 3,
  parameter bit FIRST_PLAYER = 1'b0,
  parameter int IDX_W        = (SIZE > 2) ? $clog2(SIZE) : 1,
  parameter int CNT_W        = $clog2(SIZE*SIZE+1)
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   new_game,
  input  logic                   move_valid,
  input  logic [IDX_W-1:0]       move_row,
  input  logic [IDX_W-1:0]       move_col,
  output logic                   ready,
  output logic                   move_ack,
  output logic                   move_err,
  output logic                   turn,
  output logic [2*SIZE*SIZE-1:0] board,
  output logic [CNT_W-1:0]       move_count,
  output logic [1:0]             winner,
  output logic                   draw,
  output logic                   game_over
);

  localparam int NC = SIZE*SIZE;

  state_t state;

  logic [1:0]    mark;
  logic [NC-1:0] hit;
  logic [NC-1:0] empty;
  logic [NC-1:0] eq;
  logic [NC-1:0] eqt;
  logic [NC-1:0] we;
  logic [SIZE-1:0] row_w;
  logic [SIZE-1:0] col_w;
  logic [SIZE-1:0] dg;
  logic [SIZE-1:0] ad;
  logic cell_free;
  logic accept;
  logic line_win;

  assign mark  = mark_of(turn);
  assign ready = (state == PLAY);

  // An out-of-range row/col matches no cell, so it is never free.
  assign cell_free = |(hit & empty);
  assign accept = ready && move_valid
               && !new_game && cell_free;

  for (genvar r = 0; r < SIZE; r++) begin : g_row
    for (genvar c = 0; c < SIZE; c++) begin : g_col
      localparam int I = r*SIZE + c;

      assign hit[I] = (move_row == IDX_W'(r))
                   && (move_col == IDX_W'(c));
      assign empty[I] = (board[2*I +: 2] == CELL_N);
      assign eq[I] = (board[2*I +: 2] == mark);
      assign eqt[c*SIZE + r] = eq[I];
      assign we[I] = accept && hit[I];

      board_cell u_cell (
        .clk    (clk),
        .Reset  (Reset),
        .clr    (new_game),
        .we     (we[I]),
        .player (turn),
        .q      (board[2*I +: 2])
      );
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_line
    assign row_w[i] = &eq[i*SIZE +: SIZE];
    assign col_w[i] = &eqt[i*SIZE +: SIZE];
    assign dg[i] = eq[i*SIZE + i];
    assign ad[i] = eq[i*SIZE + SIZE-1-i];
  end

  assign line_win = (|row_w) || (|col_w)
                 || (&dg) || (&ad);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= PLAY;
      turn       <= FIRST_PLAYER;
      move_count <= '0;
      winner     <= WIN_NONE;
      draw       <= 1'b0;
      game_over  <= 1'b0;
      move_ack   <= 1'b0;
      move_err   <= 1'b0;
    end else begin
      move_ack <= 1'b0;
      move_err <= 1'b0;
      if (new_game) begin
        state      <= PLAY;
        turn       <= FIRST_PLAYER;
        move_count <= '0;
        winner     <= WIN_NONE;
        draw       <= 1'b0;
        game_over  <= 1'b0;
      end else begin
        unique case (state)
          PLAY: begin
            if (move_valid) begin
              if (cell_free) begin
                move_count <= move_count + CNT_W'(1);
                move_ack   <= 1'b1;
                state      <= CHECK;
              end else begin
                move_err <= 1'b1;
              end
            end
          end
          CHECK: begin
            if (line_win) begin
              winner    <= mark;
              game_over <= 1'b1;
              state     <= OVER;
            end else if (move_count == CNT_W'(NC)) begin
              draw      <= 1'b1;
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              turn  <= ~turn;
              state <= PLAY;
            end
          end
          OVER: begin
            move_err <= move_valid;
          end
          default: begin
            state <= PLAY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttt_board.sv
// Randomised + directed bench for ttt_board at SIZE 3 and 4
// against a game-rules reference model.
module tb_ttt_board;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Reset = 1'b0;
  logic ng [2];
  logic mv [2];
  logic [1:0] mr [2];
  logic [1:0] mc [2];

  logic r3, a3, e3, t3, d3, g3;
  logic [17:0] b3;
  logic [3:0] cnt3;
  logic [1:0] w3;

  logic r4, a4, e4, t4, d4, g4;
  logic [31:0] b4;
  logic [4:0] cnt4;
  logic [1:0] w4;

  ttt_board #(.SIZE(3), .FIRST_PLAYER(1'b0)) dut3 (
    .clk        (clk),
    .Reset      (Reset),
    .new_game   (ng[0]),
    .move_valid (mv[0]),
    .move_row   (mr[0]),
    .move_col   (mc[0]),
    .ready      (r3),
    .move_ack   (a3),
    .move_err   (e3),
    .turn       (t3),
    .board      (b3),
    .move_count (cnt3),
    .winner     (w3),
    .draw       (d3),
    .game_over  (g3)
  );

  ttt_board #(.SIZE(4), .FIRST_PLAYER(1'b0)) dut4 (
    .clk        (clk),
    .Reset      (Reset),
    .new_game   (ng[1]),
    .move_valid (mv[1]),
    .move_row   (mr[1]),
    .move_col   (mc[1]),
    .ready      (r4),
    .move_ack   (a4),
    .move_err   (e4),
    .turn       (t4),
    .board      (b4),
    .move_count (cnt4),
    .winner     (w4),
    .draw       (d4),
    .game_over  (g4)
  );

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  task automatic cmp(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: plain game state per instance.
  // ph: 0 waiting for a move, 1 result pending, 2 game finished.
  int m_cell [2][64];
  int m_turn [2];
  int m_cnt  [2];
  int m_win  [2];
  int m_draw [2];
  int m_ph   [2];
  int m_ack  [2];
  int m_err  [2];

  function automatic int sz_of(input int k);
    return (k == 0) ? 3 : 4;
  endfunction

  function automatic void m_clear(input int k);
    for (int i = 0; i < 64; i++) m_cell[k][i] = 0;
    m_turn[k] = 0;
    m_cnt[k]  = 0;
    m_win[k]  = 0;
    m_draw[k] = 0;
    m_ph[k]   = 0;
    m_ack[k]  = 0;
    m_err[k]  = 0;
  endfunction

  function automatic bit m_line(input int k, input int m);
    int sz;
    bit all;
    sz = sz_of(k);
    for (int r = 0; r < sz; r++) begin
      all = 1;
      for (int c = 0; c < sz; c++)
        if (m_cell[k][r*sz+c] != m) all = 0;
      if (all) return 1;
    end
    for (int c = 0; c < sz; c++) begin
      all = 1;
      for (int r = 0; r < sz; r++)
        if (m_cell[k][r*sz+c] != m) all = 0;
      if (all) return 1;
    end
    all = 1;
    for (int i = 0; i < sz; i++)
      if (m_cell[k][i*sz+i] != m) all = 0;
    if (all) return 1;
    all = 1;
    for (int i = 0; i < sz; i++)
      if (m_cell[k][i*sz+sz-1-i] != m) all = 0;
    return all;
  endfunction

  function automatic void m_step(input int k);
    int sz, mark, r, c;
    sz = sz_of(k);
    r = int'(mr[k]);
    c = int'(mc[k]);
    m_ack[k] = 0;
    m_err[k] = 0;
    if (ng[k]) begin
      m_clear(k);
      return;
    end
    mark = (m_turn[k] != 0) ? 3 : 1;
    if (m_ph[k] == 1) begin
      if (m_line(k, mark)) begin
        m_win[k] = mark;
        m_ph[k] = 2;
      end else if (m_cnt[k] == sz*sz) begin
        m_draw[k] = 1;
        m_ph[k] = 2;
      end else begin
        m_turn[k] = 1 - m_turn[k];
        m_ph[k] = 0;
      end
    end else if (mv[k]) begin
      if (m_ph[k] == 0 && r < sz && c < sz
          && m_cell[k][r*sz+c] == 0) begin
        m_cell[k][r*sz+c] = mark;
        m_cnt[k]++;
        m_ack[k] = 1;
        m_ph[k] = 1;
      end else begin
        m_err[k] = 1;
      end
    end
  endfunction

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      m_clear(0);
      m_clear(1);
    end else begin
      m_step(0);
      m_step(1);
    end
  end

  function automatic logic [63:0] expb(input int k);
    logic [63:0] v;
    int sz;
    v = '0;
    sz = sz_of(k);
    for (int i = 0; i < sz*sz; i++)
      v[2*i +: 2] = 2'(m_cell[k][i]);
    return v;
  endfunction

  task automatic chk(input int k,
                     input logic [63:0] b,
                     input logic [7:0] cnt,
                     input logic [1:0] w,
                     input logic d, g, a, e, t, r);
    cmp($sformatf("board%0d", k), b, expb(k));
    cmp($sformatf("count%0d", k), 64'(cnt), 64'(m_cnt[k]));
    cmp($sformatf("winner%0d", k), 64'(w), 64'(m_win[k]));
    cmp($sformatf("draw%0d", k), 64'(d), 64'(m_draw[k]));
    cmp($sformatf("over%0d", k), 64'(g),
        64'((m_win[k] != 0) || (m_draw[k] != 0)));
    cmp($sformatf("ack%0d", k), 64'(a), 64'(m_ack[k]));
    cmp($sformatf("err%0d", k), 64'(e), 64'(m_err[k]));
    cmp($sformatf("turn%0d", k), 64'(t), 64'(m_turn[k]));
    cmp($sformatf("ready%0d", k), 64'(r), 64'(m_ph[k] == 0));
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk(0, 64'(b3), 8'(cnt3), w3, d3, g3, a3, e3, t3, r3);
      chk(1, 64'(b4), 8'(cnt4), w4, d4, g4, a4, e4, t4, r4);
    end
  end

  // Called at a negedge; returns at the negedge two cycles later.
  task automatic move(input int k, input int r, input int c,
                      output logic a, output logic e);
    mv[k] = 1'b1;
    mr[k] = 2'(r);
    mc[k] = 2'(c);
    @(negedge clk);
    mv[k] = 1'b0;
    a = (k == 0) ? a3 : a4;
    e = (k == 0) ? e3 : e4;
    @(negedge clk);
  endtask

  task automatic newg(input int k);
    ng[k] = 1'b1;
    @(negedge clk);
    ng[k] = 1'b0;
  endtask

  initial begin
    logic a, e;
    int dr [9];
    int dc [9];
    int qr [8];
    int qc [8];
    for (int k = 0; k < 2; k++) begin
      ng[k] = 1'b0;
      mv[k] = 1'b0;
      mr[k] = 2'd0;
      mc[k] = 2'd0;
    end
    #1 Reset = 1'b1;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    started = 1'b1;
    cmp("rst_ready", 64'(r3), 64'(1));
    cmp("rst_board", 64'(b3), 64'(0));
    cmp("rst_count", 64'(cnt4), 64'(0));
    cmp("rst_over", 64'(g4), 64'(0));

    // Row-0 win for X
    move(0, 0, 0, a, e);
    move(0, 1, 0, a, e);
    move(0, 0, 1, a, e);
    move(0, 1, 1, a, e);
    move(0, 0, 2, a, e);
    cmp("t1_winner", 64'(w3), 64'(2'b01));
    cmp("t1_over", 64'(g3), 64'(1));
    cmp("t1_count", 64'(cnt3), 64'(5));
    cmp("t1_ready", 64'(r3), 64'(0));
    cmp("t1_turn", 64'(t3), 64'(0));

    // Occupied cell and out-of-range row
    newg(0);
    move(0, 1, 1, a, e);
    cmp("t2_ack", 64'(a), 64'(1));
    move(0, 1, 1, a, e);
    cmp("t2_err", 64'(e), 64'(1));
    cmp("t2_noack", 64'(a), 64'(0));
    cmp("t2_count", 64'(cnt3), 64'(1));
    cmp("t2_cell", 64'(b3[9:8]), 64'(2'b01));
    cmp("t2_turn", 64'(t3), 64'(1));
    move(0, 3, 0, a, e);
    cmp("t2_range_err", 64'(e), 64'(1));
    cmp("t2_range_cnt", 64'(cnt3), 64'(1));

    // Draw
    newg(0);
    dr = '{0, 0, 0, 1, 1, 2, 1, 2, 2};
    dc = '{0, 1, 2, 1, 0, 0, 2, 2, 1};
    for (int i = 0; i < 9; i++) move(0, dr[i], dc[i], a, e);
    cmp("t3_draw", 64'(d3), 64'(1));
    cmp("t3_winner", 64'(w3), 64'(0));
    cmp("t3_count", 64'(cnt3), 64'(9));
    move(0, 0, 0, a, e);
    cmp("t3_over_err", 64'(e), 64'(1));
    cmp("t3_over_ack", 64'(a), 64'(0));

    // new_game wins over move_valid in OVER
    ng[0] = 1'b1;
    mv[0] = 1'b1;
    mr[0] = 2'd2;
    mc[0] = 2'd2;
    @(negedge clk);
    ng[0] = 1'b0;
    mv[0] = 1'b0;
    cmp("t6_ack", 64'(a3), 64'(0));
    cmp("t6_err", 64'(e3), 64'(0));
    cmp("t6_ready", 64'(r3), 64'(1));
    cmp("t6_board", 64'(b3), 64'(0));

    // SIZE 4: O completes the anti-diagonal
    qr = '{0, 0, 0, 1, 1, 2, 2, 3};
    qc = '{0, 3, 1, 2, 0, 1, 2, 0};
    for (int i = 0; i < 8; i++) move(1, qr[i], qc[i], a, e);
    cmp("t4_winner", 64'(w4), 64'(2'b11));
    cmp("t4_count", 64'(cnt4), 64'(8));
    cmp("t4_c03", 64'(b4[7:6]), 64'(2'b11));
    cmp("t4_c12", 64'(b4[13:12]), 64'(2'b11));
    cmp("t4_c21", 64'(b4[19:18]), 64'(2'b11));
    cmp("t4_c30", 64'(b4[25:24]), 64'(2'b11));

    // Async reset while the third move is being checked
    move(0, 0, 0, a, e);
    move(0, 1, 1, a, e);
    mv[0] = 1'b1;
    mr[0] = 2'd2;
    mc[0] = 2'd2;
    @(posedge clk);
    #1;
    mv[0] = 1'b0;
    Reset = 1'b1;
    #1;
    cmp("t5_board", 64'(b3), 64'(0));
    cmp("t5_count", 64'(cnt3), 64'(0));
    cmp("t5_turn", 64'(t3), 64'(0));
    cmp("t5_ack", 64'(a3), 64'(0));
    @(negedge clk);
    Reset = 1'b0;
    move(0, 0, 0, a, e);
    cmp("t5_re_ack", 64'(a), 64'(1));
    cmp("t5_re_cell", 64'(b3[1:0]), 64'(2'b01));

    // Random play on both boards
    repeat (3000) begin
      for (int k = 0; k < 2; k++) begin
        ng[k] = ($urandom_range(0, 39) == 0);
        mv[k] = 1'($urandom_range(0, 1));
        mr[k] = 2'($urandom_range(0, 3));
        mc[k] = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      ng[k] = 1'b0;
      mv[k] = 1'b0;
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
